microwave_ctrl_fsm: RTL and testbench
=====================================

Name: microwave_ctrl_fsm

Overview:
Front-panel control FSM that produces the status/mode interface consumed by the LED display master: `start`, `idle`, `mode[1:0]` and `mini_rst`. It accepts raw push-buttons and a cook-time switch value, synchronises and debounces the buttons, and runs an IDLE/COOK/PAUSE/DONE state machine. It also runs a seconds countdown from an internal 1 Hz tick. It sits between the board buttons/switches and the LED, display and beeper blocks.

Parameters:
- CLK_HZ, 100000000, sys_clk frequency; the seconds tick fires every CLK_HZ cycles.
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change.
- TIME_W, 8, width of the cook-time and remaining-time values (seconds).
- DONE_HOLD, 3, seconds spent in DONE before returning to IDLE.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- btn_start  in  1  raw start/resume button
- btn_stop  in  1  raw stop/pause/cancel button
- btn_mode  in  1  raw power-mode cycle button
- door_open  in  1  raw door switch; used only with the optional feature
- time_set  in  TIME_W  cook time in seconds, from switches
- start  out  1  high while cooking
- idle  out  1  high while idle
- mode  out  2  power mode: 01 low, 10 normal, 11 high; 00 is never driven
- mini_rst  out  1  one-cycle pulse that restarts the display pattern counter
- remaining  out  TIME_W  seconds left
- done  out  1  one-cycle pulse when the countdown expires
- state  out  2  IDLE=00, COOK=01, PAUSE=10, DONE=11

Behaviour:
- Reset values: state=IDLE, idle=1, start=0, mode=10, mini_rst=0, remaining=0, done=0. Tick counter, debouncers and synchronisers are all cleared.
- Button input path:
  - Each button goes through a 2-FF synchroniser, then a debouncer.
  - The debounced level changes only after DB_CYCLES consecutive cycles of a differing synchronised level.
  - A rising edge of the debounced level gives a 1-cycle pulse (p_start, p_stop, p_mode).
  - Raw-press to state-change latency is exactly 2+DB_CYCLES+1 cycles. Releases generate nothing.
- Tick counter:
  - Counts 0..CLK_HZ-1 only in COOK and DONE; a tick fires on the cycle it equals CLK_HZ-1, then it wraps to 0.
  - It is cleared on IDLE->COOK and on entry to DONE.
  - It holds its value in PAUSE, so a resume continues the partial second.
- IDLE (idle=1, start=0):
  - p_mode cycles mode 01->10->11->01.
  - p_start with time_set!=0: remaining<=time_set, go to COOK, pulse mini_rst on the transition cycle.
  - p_start with time_set==0 is ignored.
- COOK (start=1, idle=0):
  - Each tick decrements remaining.
  - A tick with remaining==1: remaining<=0, done pulses, go to DONE.
  - p_stop goes to PAUSE. p_start and p_mode are ignored.
- PAUSE (start=0, idle=0):
  - p_start returns to COOK with no mini_rst.
  - p_stop goes to IDLE and sets remaining<=0.
  - p_mode is ignored.
- DONE (start=0, idle=0):
  - Counts DONE_HOLD ticks, then goes to IDLE.
  - p_stop goes to IDLE immediately.
- Simultaneous p_start and p_stop in the same cycle: stop wins in every state.
- A tick and p_stop in the same COOK cycle: the decrement is applied, then the FSM goes to PAUSE. If that decrement reaches 0, DONE takes priority over PAUSE.
- mode is held unchanged outside IDLE.
- All outputs are registered. time_set is sampled only on the IDLE->COOK cycle.
- Asserting sys_rst at any point returns all state to the reset values immediately.

Optional Feature:
- Macro: MWCTRL_DOOR_INTERLOCK_EN.
- Defined:
  - door_open is 2-FF synchronised but not debounced.
  - A synchronised door_open=1 in COOK forces PAUSE on the next cycle, with priority over the tick.
  - p_start in IDLE or PAUSE is ignored while the door is open.
- Undefined: door_open is unused and the FSM behaves exactly as described above.

Test Plan:
- Bench settings: CLK_HZ=10, DB_CYCLES=4, TIME_W=8, DONE_HOLD=3.
- Reset, then press btn_mode three times -> mode goes 10 -> 11 -> 01 -> 10. idle=1, start=0 and remaining=0 throughout.
- time_set=3, press start -> state=COOK and mini_rst pulses once, 7 cycles after the raw rise. remaining reads 3,2,1,0 at 10-cycle intervals. done pulses on the 3rd tick. DONE lasts 30 cycles, then IDLE.
- time_set=5, start, wait 13 cycles, then stop -> PAUSE with remaining=4 and the tick counter frozen. Start again -> COOK with no mini_rst, and the next decrement arrives after the remaining partial second. Stop twice -> IDLE with remaining=0.
- btn_start and btn_stop raised on the same cycle during COOK -> PAUSE. A 3-cycle glitch on btn_mode in IDLE -> mode unchanged.
- time_set=0 with start pressed -> stays IDLE. Assert sys_rst mid-COOK -> reset values on all outputs immediately.
- With MWCTRL_DOOR_INTERLOCK_EN: raise door_open during COOK -> PAUSE within 3 cycles. Press start while the door is open -> stays PAUSE. Clear door_open, press start -> COOK.

Source files
------------

// File: rtl/microwave_ctrl_fsm_if.sv
// Front-panel bundle between the board buttons/switches and the microwave control FSM.
// The master side drives buttons and switches; the slave side returns status and mode.
interface microwave_ctrl_fsm_if #(
    parameter int TIME_W = 8
);
    logic              btn_start;
    logic              btn_stop;
    logic              btn_mode;
    logic              door_open;
    logic [TIME_W-1:0] time_set;
    logic              start;
    logic              idle;
    logic [1:0]        mode;
    logic              mini_rst;
    logic [TIME_W-1:0] remaining;
    logic              done;
    logic [1:0]        state;

    modport master (
        output btn_start, btn_stop, btn_mode, door_open, time_set,
        input  start, idle, mode, mini_rst, remaining, done, state
    );

    modport slave (
        input  btn_start, btn_stop, btn_mode, door_open, time_set,
        output start, idle, mode, mini_rst, remaining, done, state
    );
endinterface

// File: rtl/microwave_ctrl_fsm.sv
// Microwave front-panel FSM: button sync/debounce, IDLE/COOK/PAUSE/DONE control, seconds countdown.
// Optional door interlock is enabled by defining MWCTRL_DOOR_INTERLOCK_EN.
module microwave_ctrl_fsm #(
    parameter int CLK_HZ    = 100000000,
    parameter int DB_CYCLES = 1000000,
    parameter int TIME_W    = 8,
    parameter int DONE_HOLD = 3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    microwave_ctrl_fsm_if.slave  bus
);
    localparam int TICK_W = (CLK_HZ > 1)    ? $clog2(CLK_HZ)    : 1;
    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COOK  = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t              state_reg;
    logic                start_reg, idle_reg, mini_rst_reg, done_reg;
    logic [1:0]          mode_reg;
    logic [TIME_W-1:0]   remaining_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;
    logic [TICK_W-1:0]   tick_cnt_reg;

    logic [2:0] btn_raw, btn_pulse;
    logic       p_start, p_stop, p_mode;
    logic       door_force, door_block;
    logic       counting, tick, cook_go, expire;

    assign btn_raw = {bus.btn_mode, bus.btn_stop, bus.btn_start};
    assign p_start = btn_pulse[0];
    assign p_stop  = btn_pulse[1];
    assign p_mode  = btn_pulse[2];

    // Level flips only after DB_CYCLES consecutive differing samples; a rise emits one pulse.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_btn
            logic            sync1_reg, sync2_reg, level_reg, pulse_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    pulse_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    pulse_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_W'(DB_CYCLES - 1)) begin
                        cnt_reg   <= '0;
                        level_reg <= sync2_reg;
                        pulse_reg <= sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign btn_pulse[gi] = pulse_reg;
        end
    endgenerate

`ifdef MWCTRL_DOOR_INTERLOCK_EN
    logic door_sync1_reg, door_sync2_reg;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            door_sync1_reg <= 1'b0;
            door_sync2_reg <= 1'b0;
        end else begin
            door_sync1_reg <= bus.door_open;
            door_sync2_reg <= door_sync1_reg;
        end
    end

    assign door_block = door_sync2_reg;
    assign door_force = door_sync2_reg && (state_reg == S_COOK);
`else
    logic unused_door;
    assign unused_door = bus.door_open;
    assign door_block  = 1'b0;
    assign door_force  = 1'b0;
`endif

    // A forced door pause freezes the partial second exactly like PAUSE does.
    assign counting = (state_reg == S_DONE) || ((state_reg == S_COOK) && !door_force);
    assign tick     = counting && (tick_cnt_reg == TICK_W'(CLK_HZ - 1));
    assign cook_go  = (state_reg == S_IDLE) && p_start && !p_stop &&
                      (bus.time_set != '0) && !door_block;
    assign expire   = (state_reg == S_COOK) && !door_force && tick &&
                      (remaining_reg == TIME_W'(1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_cnt_reg <= '0;
        end else if (cook_go || expire) begin
            tick_cnt_reg <= '0;
        end else if (counting) begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg     <= S_IDLE;
            start_reg     <= 1'b0;
            idle_reg      <= 1'b1;
            mode_reg      <= 2'b10;
            mini_rst_reg  <= 1'b0;
            done_reg      <= 1'b0;
            remaining_reg <= '0;
            hold_cnt_reg  <= '0;
        end else begin
            mini_rst_reg <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (p_mode)
                        mode_reg <= (mode_reg == 2'b11) ? 2'b01 : mode_reg + 2'b01;
                    if (cook_go) begin
                        remaining_reg <= bus.time_set;
                        state_reg     <= S_COOK;
                        start_reg     <= 1'b1;
                        idle_reg      <= 1'b0;
                        mini_rst_reg  <= 1'b1;
                    end
                end
                S_COOK: begin
                    if (door_force) begin
                        state_reg <= S_PAUSE;
                        start_reg <= 1'b0;
                    end else begin
                        if (tick)
                            remaining_reg <= remaining_reg - 1'b1;
                        // Expiry outranks a same-cycle stop.
                        if (expire) begin
                            state_reg    <= S_DONE;
                            start_reg    <= 1'b0;
                            done_reg     <= 1'b1;
                            hold_cnt_reg <= '0;
                        end else if (p_stop) begin
                            state_reg <= S_PAUSE;
                            start_reg <= 1'b0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (p_stop) begin
                        state_reg     <= S_IDLE;
                        idle_reg      <= 1'b1;
                        remaining_reg <= '0;
                    end else if (p_start && !door_block) begin
                        state_reg <= S_COOK;
                        start_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (p_stop) begin
                        state_reg <= S_IDLE;
                        idle_reg  <= 1'b1;
                    end else if (tick) begin
                        if (hold_cnt_reg == HOLD_W'(DONE_HOLD - 1)) begin
                            state_reg <= S_IDLE;
                            idle_reg  <= 1'b1;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    idle_reg  <= 1'b1;
                    start_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state     = state_reg;
    assign bus.start     = start_reg;
    assign bus.idle      = idle_reg;
    assign bus.mode      = mode_reg;
    assign bus.mini_rst  = mini_rst_reg;
    assign bus.done      = done_reg;
    assign bus.remaining = remaining_reg;
endmodule

// File: tb/tb_microwave_ctrl_fsm.sv
// Scoreboard bench for microwave_ctrl_fsm: a behavioural model predicts every output change
// (value and cycle); a negedge monitor compares each change the DUT presents.
module tb_microwave_ctrl_fsm;
    localparam int CLK_HZ    = 10;
    localparam int DB_CYCLES = 4;
    localparam int TIME_W    = 8;
    localparam int DONE_HOLD = 3;
    localparam int LAT       = 2 + DB_CYCLES + 1;
    localparam int MAXC      = 16384;
    localparam int M_IDLE = 0, M_COOK = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    microwave_ctrl_fsm_if #(.TIME_W(TIME_W)) bus ();

    microwave_ctrl_fsm #(
        .CLK_HZ(CLK_HZ), .DB_CYCLES(DB_CYCLES), .TIME_W(TIME_W), .DONE_HOLD(DONE_HOLD)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          at;
        logic [15:0] snap;
    } exp_t;

    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    bit   ev_s [MAXC];
    bit   ev_p [MAXC];
    bit   ev_m [MAXC];
    exp_t exp_q [$];

    // Behavioural model: panel state plus position inside the current second.
    int          m_state = M_IDLE;
    int          m_mode  = 2;
    int          m_rem   = 0;
    int          m_phase = 0;
    int          m_hold  = 0;
    bit          m_done  = 1'b0;
    bit          m_mini  = 1'b0;
    bit          door_d1 = 1'b0;
    bit          door_d2 = 1'b0;
    bit          rst_seen = 1'b0;
    logic [15:0] m_prev  = 16'h2004;

    function automatic logic [15:0] model_snap();
        return {m_state[1:0], m_mode[1:0], m_rem[7:0], m_state == M_COOK,
                m_state == M_IDLE, m_done, m_mini};
    endfunction

    function automatic void model_reset();
        m_state = M_IDLE; m_mode = 2; m_rem = 0; m_phase = 0; m_hold = 0;
        m_done = 1'b0; m_mini = 1'b0; door_d1 = 1'b0; door_d2 = 1'b0;
    endfunction

    function automatic void model_push();
        logic [15:0] s;
        s = model_snap();
        if (s !== m_prev) begin
            exp_q.push_back('{cyc, s});
            m_prev = s;
        end
    endfunction

    function automatic void model_step();
        bit s, p, m, door_eff, active, second;
        s = ev_s[cyc % MAXC]; ev_s[cyc % MAXC] = 1'b0;
        p = ev_p[cyc % MAXC]; ev_p[cyc % MAXC] = 1'b0;
        m = ev_m[cyc % MAXC]; ev_m[cyc % MAXC] = 1'b0;
`ifdef MWCTRL_DOOR_INTERLOCK_EN
        door_eff = door_d2; door_d2 = door_d1; door_d1 = bus.door_open;
`else
        door_eff = 1'b0;
`endif
        m_done = 1'b0;
        m_mini = 1'b0;
        active = (m_state == M_DONE) || (m_state == M_COOK && !door_eff);
        second = active && (m_phase == CLK_HZ - 1);
        if (active) m_phase = (m_phase + 1) % CLK_HZ;
        case (m_state)
            M_IDLE: begin
                if (m) m_mode = (m_mode % 3) + 1;
                if (s && !p && bus.time_set != 0 && !door_eff) begin
                    m_rem = int'(bus.time_set); m_state = M_COOK; m_mini = 1'b1; m_phase = 0;
                end
            end
            M_COOK: begin
                if (door_eff) m_state = M_PAUSE;
                else begin
                    if (second) m_rem = m_rem - 1;
                    if (second && m_rem == 0) begin
                        m_state = M_DONE; m_done = 1'b1; m_phase = 0; m_hold = 0;
                    end else if (p) m_state = M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (p) begin m_state = M_IDLE; m_rem = 0; end
                else if (s && !door_eff) m_state = M_COOK;
            end
            default: begin
                if (p) m_state = M_IDLE;
                else if (second) begin
                    m_hold = m_hold + 1;
                    if (m_hold == DONE_HOLD) m_state = M_IDLE;
                end
            end
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst && !rst_seen) begin
            rst_seen = 1'b1;
            model_reset();
            model_push();
        end else begin
            cyc = cyc + 1;
            if (rst) model_reset();
            else begin
                rst_seen = 1'b0;
                model_step();
            end
            model_push();
        end
    end

    function automatic logic [15:0] dut_snap();
        return {bus.state, bus.mode, bus.remaining, bus.start, bus.idle, bus.done, bus.mini_rst};
    endfunction

    logic [15:0] dut_last;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin : monitor
        logic [15:0] s;
        exp_t        e;
        if (mon_en) begin
            s = dut_snap();
            if (s !== dut_last) begin
                dut_last = s;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, s);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at == cyc && e.snap === s) begin
                        passes++;
                        $display("change cyc=%0d snap=%h ok", cyc, s);
                    end else
                        $display("FAIL output_change got cyc=%0d snap=%h required cyc=%0d snap=%h",
                                 cyc, s, e.at, e.snap);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
            $display("check %s = %0h ok", name, act);
        end else
            $display("FAIL %s got=%0h required=%0h", name, act, req);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(bus.state), 32'd0);
        check({tag, "_idle"}, 32'(bus.idle), 32'd1);
        check({tag, "_start"}, 32'(bus.start), 32'd0);
        check({tag, "_mode"}, 32'(bus.mode), 32'd2);
        check({tag, "_mini_rst"}, 32'(bus.mini_rst), 32'd0);
        check({tag, "_remaining"}, 32'(bus.remaining), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    // Raise buttons for 'hold' sampled cycles; debounced presses are scheduled LAT cycles out.
    task automatic press(input bit bs, input bit bp, input bit bm, input int hold,
                         input bit glitch, input int gap);
        int n;
        @(posedge clk); #1;
        n = cyc;
        bus.btn_start = bs; bus.btn_stop = bp; bus.btn_mode = bm;
        if (!glitch) begin
            if (bs) ev_s[(n + LAT) % MAXC] = 1'b1;
            if (bp) ev_p[(n + LAT) % MAXC] = 1'b1;
            if (bm) ev_m[(n + LAT) % MAXC] = 1'b1;
        end
        repeat (hold) @(posedge clk);
        #1;
        bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_mode = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic tap(input bit bs, input bit bp, input bit bm);
        press(bs, bp, bm, int'($urandom_range(DB_CYCLES, DB_CYCLES + 5)), 1'b0,
              12 + int'($urandom_range(0, 6)));
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_start = 1'b0; bus.btn_stop = 1'b0; bus.btn_mode = 1'b0;
        bus.door_open = 1'b0; bus.time_set = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        exp_q.delete();
        dut_last = dut_snap();
        mon_en = 1'b1;
        wait_cycles(2);

        repeat (3) tap(1'b0, 1'b0, 1'b1);
        check("mode_after_three", 32'(bus.mode), 32'd2);

        bus.time_set = 8'd3;
        tap(1'b1, 1'b0, 1'b0);
        wait_cycles(70);
        check("cook3_back_idle", 32'(bus.state), 32'd0);

        bus.time_set = 8'd5;
        press(1'b1, 1'b0, 1'b0, DB_CYCLES + 1, 1'b0, 12 - (DB_CYCLES + 1));
        tap(1'b0, 1'b1, 1'b0);
        check("pause_state", 32'(bus.state), 32'd2);
        check("pause_remaining", 32'(bus.remaining), 32'd4);
        wait_cycles(25);
        check("pause_frozen", 32'(bus.remaining), 32'd4);
        tap(1'b1, 1'b0, 1'b0);
        wait_cycles(20);
        tap(1'b0, 1'b1, 1'b0);
        tap(1'b0, 1'b1, 1'b0);
        check("stop_twice_idle", 32'(bus.state), 32'd0);
        check("stop_twice_rem", 32'(bus.remaining), 32'd0);

        bus.time_set = 8'd9;
        tap(1'b1, 1'b0, 1'b0);
        tap(1'b1, 1'b1, 1'b0);
        check("start_stop_same_cycle", 32'(bus.state), 32'd2);
        tap(1'b0, 1'b1, 1'b0);

        press(1'b0, 1'b0, 1'b1, 3, 1'b1, 14);
        check("glitch_mode_kept", 32'(bus.mode), 32'd2);

        bus.time_set = 8'd0;
        tap(1'b1, 1'b0, 1'b0);
        check("zero_time_idle", 32'(bus.state), 32'd0);

        bus.time_set = 8'd4;
        tap(1'b1, 1'b0, 1'b0);
        check("pre_reset_cook", 32'(bus.state), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check_reset_outputs("midcook_reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(12);

`ifdef MWCTRL_DOOR_INTERLOCK_EN
        bus.time_set = 8'd6;
        tap(1'b1, 1'b0, 1'b0);
        bus.door_open = 1'b1;
        wait_cycles(3);
        check("door_pause", 32'(bus.state), 32'd2);
        tap(1'b1, 1'b0, 1'b0);
        check("door_blocks_start", 32'(bus.state), 32'd2);
        bus.door_open = 1'b0;
        wait_cycles(4);
        tap(1'b1, 1'b0, 1'b0);
        check("door_closed_resume", 32'(bus.state), 32'd1);
        tap(1'b0, 1'b1, 1'b0);
        tap(1'b0, 1'b1, 1'b0);
`endif

        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    bus.time_set = 8'($urandom_range(0, 5));
                    tap(1'b1, 1'b0, 1'b0);
                end
                1: tap(1'b0, 1'b1, 1'b0);
                2: tap(1'b0, 1'b0, 1'b1);
                3: tap(1'b1, 1'b1, 1'b0);
                default: press(1'($urandom_range(0, 1)), 1'b0, 1'b1,
                               int'($urandom_range(1, DB_CYCLES - 1)), 1'b1, 14);
            endcase
            wait_cycles(int'($urandom_range(0, 40)));
        end

        wait_cycles(100);
        mon_en = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
